// File: rtl/dmem_mmio_if.sv
// Bus between the single-cycle datapath / output consumer and dmem_mmio.
// master: datapath plus consumer side. slave: the memory responder.
interface dmem_mmio_if;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        irq;

    modport master (
        output mem_write, addr, wdata, out_ready,
        input  rdata, out_data, out_valid, irq
    );

    modport slave (
        input  mem_write, addr, wdata, out_ready,
        output rdata, out_data, out_valid, irq
    );
endinterface

// File: rtl/dmem_mmio.sv
// dmem_mmio: word RAM plus an MMIO page (TIMER, CMP, STATUS, output FIFO).
// Loads are combinational from addr; stores take effect on the rising clock edge.
// Optional feature macro: DMEM_TIMER_EN enables the free-running timer, the
// compare register, the match flag and irq. Without it they read 0 and irq is 0.
module dmem_mmio #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic       clk,
    input  logic       rst,
    dmem_mmio_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [9:0]    OFF_TIMER  = 10'd0;
    localparam logic [9:0]    OFF_CMP    = 10'd1;
    localparam logic [9:0]    OFF_STATUS = 10'd2;
    localparam logic [9:0]    OFF_FIFO   = 10'd3;

    // Address decode: RAM sits at the bottom of the map, MMIO is one 4 KiB page.
    logic          is_ram_s;
    logic          is_mmio_s;
    logic [9:0]    mmio_off_s;
    logic [AW-1:0] ram_idx_s;
    logic [1:0]    unused_addr_s;

    assign is_ram_s      = (bus.addr[31:AW+2] == {(30-AW){1'b0}});
    assign is_mmio_s     = (bus.addr[31:12] == MMIO_BASE[31:12]);
    assign mmio_off_s    = bus.addr[11:2];
    assign ram_idx_s     = bus.addr[AW+1:2];
    assign unused_addr_s = bus.addr[1:0];

    logic wr_ram_s;
    logic wr_status_s;
    logic push_s;
    logic oor_s;

    assign wr_ram_s    = bus.mem_write && is_ram_s;
    assign wr_status_s = bus.mem_write && !is_ram_s && is_mmio_s && (mmio_off_s == OFF_STATUS);
    assign push_s      = bus.mem_write && !is_ram_s && is_mmio_s && (mmio_off_s == OFF_FIFO);
    assign oor_s       = bus.mem_write && !is_ram_s && !is_mmio_s;

    // ------------------------------------------------------------------
    // Word RAM (contents deliberately not reset)
    // ------------------------------------------------------------------
    logic [31:0] ram_q [DEPTH];

    // RAM store port
    always_ff @(posedge clk) begin
        if (wr_ram_s) begin
            ram_q[ram_idx_s] <= bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_ok_s;

    assign full_s    = (count_q == FULL_CNT);
    assign empty_s   = (count_q == {CW{1'b0}});
    assign pop_s     = !empty_s && bus.out_ready;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok_s = push_s && (!full_s || pop_s);

    // FIFO entry storage; only the slot under the write pointer changes
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_q[wr_ptr_q] <= bus.wdata;
        end
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Timer / compare
    // ------------------------------------------------------------------
    logic [31:0] timer_rd_s;
    logic [31:0] cmp_rd_s;
    logic        match_set_s;

`ifdef DMEM_TIMER_EN
    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        wr_timer_s;
    logic        wr_cmp_s;

    assign wr_timer_s  = bus.mem_write && !is_ram_s && is_mmio_s && (mmio_off_s == OFF_TIMER);
    assign wr_cmp_s    = bus.mem_write && !is_ram_s && is_mmio_s && (mmio_off_s == OFF_CMP);
    assign match_set_s = (timer_q == cmp_q);
    assign timer_rd_s  = timer_q;
    assign cmp_rd_s    = cmp_q;

    // Timer increments every cycle; a software load takes priority
    always_comb begin
        timer_d = timer_q + 32'd1;
        cmp_d   = cmp_q;
        if (wr_timer_s) begin
            timer_d = bus.wdata;
        end else begin
            timer_d = timer_q + 32'd1;
        end
        if (wr_cmp_s) begin
            cmp_d = bus.wdata;
        end else begin
            cmp_d = cmp_q;
        end
    end

    // Timer and compare registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= 32'd0;
            cmp_q   <= 32'd0;
        end else begin
            timer_q <= timer_d;
            cmp_q   <= cmp_d;
        end
    end
`else
    assign match_set_s = 1'b0;
    assign timer_rd_s  = 32'd0;
    assign cmp_rd_s    = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Sticky status bits: setting beats a write-1-to-clear in the same cycle
    // ------------------------------------------------------------------
    logic match_q, match_d;
    logic err_q, err_d;
    logic ovf_q, ovf_d;

    assign match_d = match_set_s | (match_q & ~(wr_status_s & bus.wdata[0]));
    assign err_d   = oor_s | (err_q & ~(wr_status_s & bus.wdata[3]));
    assign ovf_d   = (push_s & full_s & ~pop_s) | (ovf_q & ~(wr_status_s & bus.wdata[4]));

    // FIFO bookkeeping and sticky flags, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            match_q  <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            match_q  <= match_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] status_s;
    logic [31:0] rdata_s;

    assign status_s = {20'd0, 4'(count_q), 3'd0, ovf_q, err_q, empty_s, full_s, match_q};

    // Combinational load mux; forced to 0 while reset is asserted
    always_comb begin
        rdata_s = 32'd0;
        if (!rst) begin
            rdata_s = 32'd0;
        end else if (is_ram_s) begin
            rdata_s = ram_q[ram_idx_s];
        end else if (is_mmio_s) begin
            case (mmio_off_s)
                OFF_TIMER:  rdata_s = timer_rd_s;
                OFF_CMP:    rdata_s = cmp_rd_s;
                OFF_STATUS: rdata_s = status_s;
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.rdata     = rdata_s;
    assign bus.out_valid = !empty_s;
    assign bus.out_data  = empty_s ? 32'd0 : fifo_q[rd_ptr_q];
    assign bus.irq       = match_q;
endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus pushes expected load data and FIFO
// words into queues from a behavioural model; a negedge monitor pops and compares.
module tb_dmem_mmio;
    localparam int          DEPTH = 64;
    localparam int          FD    = 4;
    localparam logic [31:0] MB    = 32'hFFFF_0000;
`ifdef DMEM_TIMER_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_mmio_if bus();

    dmem_mmio #(.DEPTH(DEPTH), .FIFO_DEPTH(FD), .MMIO_BASE(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    logic [31:0] m_ram [DEPTH];
    logic [31:0] m_fifo [$];
    logic [31:0] m_timer = 32'd0;
    logic [31:0] m_cmp   = 32'd0;
    bit          m_match = 1'b0;
    bit          m_err   = 1'b0;
    bit          m_ovf   = 1'b0;

    // scoreboard
    logic [31:0] rd_q [$];
    logic [31:0] out_q [$];
    bit          mon_en    = 1'b0;
    bit          exp_valid = 1'b0;
    bit          exp_irq   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        int sz = m_fifo.size();
        return {20'd0, 4'(sz), 3'd0, m_ovf, m_err, (sz == 0), (sz == FD), m_match};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [9:0] off;
        if (a < DEPTH * 4) return m_ram[int'(a >> 2)];
        if ((a >> 12) != (MB >> 12)) return 32'd0;
        off = a[11:2];
        case (off)
            10'd0:   return TEN ? m_timer : 32'd0;
            10'd1:   return TEN ? m_cmp : 32'd0;
            10'd2:   return m_status();
            default: return 32'd0;
        endcase
    endfunction

    // one clock cycle: drive, record expectations, then advance the model
    task automatic cycle(input bit we, input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        bit          ram, mmio, pop, push, full, wst, mset;
        logic [9:0]  off;
        bus.mem_write = we;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.out_ready = rdy;
        if (mon_en) rd_q.push_back(m_read(a));
        exp_valid = (m_fifo.size() != 0);
        exp_irq   = m_match;
        @(posedge clk);
        #1;
        ram  = (a < DEPTH * 4);
        mmio = !ram && ((a >> 12) == (MB >> 12));
        off  = a[11:2];
        pop  = (m_fifo.size() != 0) && rdy;
        push = we && mmio && (off == 10'd3);
        full = (m_fifo.size() == FD);
        wst  = we && mmio && (off == 10'd2);
        mset = TEN && (m_timer == m_cmp);
        if (we && ram) m_ram[int'(a >> 2)] = wd;
        if (pop) void'(m_fifo.pop_front());
        if (push && (!full || pop)) begin
            m_fifo.push_back(wd);
            out_q.push_back(wd);
        end
        m_match = mset || (m_match && !(wst && wd[0]));
        m_err   = (we && !ram && !mmio) || (m_err && !(wst && wd[3]));
        m_ovf   = (push && full && !pop) || (m_ovf && !(wst && wd[4]));
        if (TEN) begin
            m_timer = (we && mmio && off == 10'd0) ? wd : m_timer + 32'd1;
            if (we && mmio && off == 10'd1) m_cmp = wd;
        end
    endtask

    // monitor: compares whatever the DUT presents against the scoreboard
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rdata_sb: no expected load entry at %0t", $time);
            end else begin
                chk("rdata", bus.rdata, rd_q.pop_front());
            end
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
            chk("irq", {31'd0, bus.irq}, {31'd0, exp_irq});
            if (bus.out_valid && bus.out_ready) begin
                if (out_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_pop: unexpected word %08h at %0t", bus.out_data, $time);
                end else begin
                    chk("out_data", bus.out_data, out_q.pop_front());
                end
            end
        end
    end

    initial begin
        int          op;
        logic [31:0] a, d;
        bit          we;

        bus.mem_write = 1'b0;
        bus.addr      = 32'h10;
        bus.wdata     = 32'd0;
        bus.out_ready = 1'b0;
        #2;
        chk("reset_rdata", bus.rdata, 32'd0);
        chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_irq", {31'd0, bus.irq}, 32'd0);
        chk("reset_out_data", bus.out_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // give every RAM word a known value
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b0);
        mon_en = 1'b1;

        cycle(1'b0, MB + 32'h8, 32'd0, 1'b0);
        // store/load with ignored byte offset
        cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        cycle(1'b0, 32'h10, 32'd0, 1'b0);
        cycle(1'b0, 32'h13, 32'd0, 1'b0);
        // out-of-range store, then clear err
        cycle(1'b1, 32'(DEPTH * 4), 32'h1234_5678, 1'b0);
        cycle(1'b0, 32'h0, 32'd0, 1'b0);
        cycle(1'b0, MB + 32'h8, 32'd0, 1'b0);
        cycle(1'b1, MB + 32'h8, 32'h8, 1'b0);
        cycle(1'b0, MB + 32'h8, 32'd0, 1'b0);
        // overflow: five pushes into a four-entry FIFO, then drain
        for (int i = 1; i <= 5; i++) cycle(1'b1, MB + 32'hC, 32'(i), 1'b0);
        cycle(1'b0, MB + 32'h8, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, MB + 32'h8, 32'd0, 1'b1);
        cycle(1'b1, MB + 32'h8, 32'h10, 1'b0);
        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) cycle(1'b1, MB + 32'hC, 32'h100 + 32'(i), 1'b0);
        cycle(1'b1, MB + 32'hC, 32'h1FF, 1'b1);
        cycle(1'b0, MB + 32'h8, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, MB + 32'h8, 32'd0, 1'b1);
        // timer wrap, match, clear and load-beats-increment
        cycle(1'b1, MB + 32'h0, 32'hFFFF_FFFE, 1'b0);
        cycle(1'b1, MB + 32'h4, 32'h1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, MB + 32'h8, 32'd0, 1'b0);
        cycle(1'b1, MB + 32'h8, 32'h1, 1'b0);
        cycle(1'b0, MB + 32'h8, 32'd0, 1'b0);
        cycle(1'b1, MB + 32'h0, 32'd5, 1'b0);
        cycle(1'b0, MB + 32'h0, 32'd0, 1'b0);
        cycle(1'b0, MB + 32'h0, 32'd0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            op = $urandom_range(0, 7);
            d  = $urandom;
            we = 1'($urandom_range(0, 1));
            case (op)
                0, 1: a = 32'($urandom_range(0, DEPTH - 1) << 2) | 32'($urandom_range(0, 3));
                2: begin a = MB + 32'hC; we = 1'b1; end
                3: begin a = MB + 32'h8; d = 32'($urandom_range(0, 31)); end
                4: a = MB + 32'($urandom_range(0, 1) << 2);
                5: a = 32'(DEPTH * 4) + 32'($urandom_range(0, 32'h0FFF_FFFF));
                6: a = MB + 32'($urandom_range(4, 1023) << 2);
                default: begin a = MB + 32'hC; we = 1'b0; end
            endcase
            cycle(we, a, d, 1'($urandom_range(0, 1)));
        end

        // drain, arm a match, part-fill, then reset mid-transfer
        for (int i = 0; i < FD + 1; i++) cycle(1'b0, MB + 32'h8, 32'd0, 1'b1);
        cycle(1'b1, MB + 32'h8, 32'h1F, 1'b0);
        cycle(1'b1, MB + 32'h4, m_timer + 32'd4, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, MB + 32'hC, 32'hA0 + 32'(i), 1'b0);
        cycle(1'b0, MB + 32'h8, 32'd0, 1'b0);
        cycle(1'b0, MB + 32'h8, 32'd0, 1'b0);
        cycle(1'b0, MB + 32'h8, 32'd0, 1'b1);
        mon_en        = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr      = 32'h10;
        #2;
        chk("pre_reset_valid", {31'd0, bus.out_valid}, {31'd0, (m_fifo.size() != 0)});
        chk("pre_reset_irq", {31'd0, bus.irq}, {31'd0, m_match});
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_irq", {31'd0, bus.irq}, 32'd0);
        chk("async_rst_rdata", bus.rdata, 32'd0);
        chk("async_rst_out_data", bus.out_data, 32'd0);
        m_fifo.delete();
        out_q.delete();
        rd_q.delete();
        m_timer = 32'd0;
        m_cmp   = 32'd0;
        m_match = 1'b0;
        m_err   = 1'b0;
        m_ovf   = 1'b0;
        @(posedge clk);
        #2;
        rst    = 1'b1;
        mon_en = 1'b1;
        cycle(1'b0, MB + 32'h8, 32'd0, 1'b1);
        cycle(1'b0, MB + 32'h0, 32'd0, 1'b1);
        cycle(1'b0, 32'h10, 32'd0, 1'b1);
        cycle(1'b0, MB + 32'h8, 32'd0, 1'b0);
        chk("scoreboard_drained", 32'(out_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
